// File: rtl/link_exerciser.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : link_exerciser                                                  |
// | Traffic generator and loopback checker for the PPM optical link.         |
// | Drives the Encoder start/data handshake (idle, single-shot, continuous,  |
// | burst) and checks Decoder output against a FIFO of sent packets.         |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   clk, rst_n        clock, asynchronous active-low reset                 |
// |   mode              0 idle, 1 single-shot, 2 continuous, 3 burst         |
// |   trigger           one-cycle start request (single-shot / burst)        |
// |   gap               idle cycles between end of packet and next start     |
// |   burst_len         packets per burst (0 treated as 1)                   |
// |   pat_sel           0/3 static, 1 incrementing, 2 LFSR                   |
// |   static_data       data for static patterns                             |
// |   clr               clear counters, expected FIFO and pattern registers  |
// |   tx_data/tx_start  packet and one-cycle start to the Encoder            |
// |   tx_avail          Encoder idle                                         |
// |   rx_data/rx_avail  Decoder output and valid                             |
// |   rx_error          Decoder error pulse                                  |
// |   rx_read           always 1                                             |
// |   *_count           saturating statistics counters                       |
// |   busy              high outside IDLE and READY                          |
// | Optional: LINK_EXERCISER_TIMEOUT_EN adds a lost-packet timeout.          |
// +--------------------------------------------------------------------------+
module link_exerciser #(
  parameter int unsigned        N_PKT     = 8,
  parameter int unsigned        CNT_W     = 32,
  parameter int unsigned        GAP_W     = 32,
  parameter int unsigned        BURST_W   = 8,
  parameter int unsigned        EXP_DEPTH = 4,
  parameter logic [N_PKT-1:0]   LFSR_TAPS = 8'hB8,
  parameter int unsigned        TIMEOUT   = 1_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         mode,
  input  logic               trigger,
  input  logic [GAP_W-1:0]   gap,
  input  logic [BURST_W-1:0] burst_len,
  input  logic [1:0]         pat_sel,
  input  logic [N_PKT-1:0]   static_data,
  input  logic               clr,
  output logic [N_PKT-1:0]   tx_data,
  output logic               tx_start,
  input  logic               tx_avail,
  input  logic [N_PKT-1:0]   rx_data,
  input  logic               rx_avail,
  input  logic               rx_error,
  output logic               rx_read,
  output logic [CNT_W-1:0]   tx_count,
  output logic [CNT_W-1:0]   rx_count,
  output logic [CNT_W-1:0]   err_count,
  output logic [CNT_W-1:0]   mismatch_count,
  output logic [CNT_W-1:0]   lost_count,
  output logic               busy
);

  localparam int unsigned AW      = (EXP_DEPTH > 1) ? $clog2(EXP_DEPTH) : 1;
  localparam logic [AW:0] C_DEPTH = (AW+1)'(EXP_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_READY   = 3'd1,
    S_WAIT_LO = 3'd2,
    S_WAIT_HI = 3'd3,
    S_GAP     = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic               tx_start_q, tx_start_d;
  logic [N_PKT-1:0]   tx_data_q, tx_data_d;
  logic [BURST_W-1:0] burst_rem_q, burst_rem_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [N_PKT-1:0]   inc_q, inc_d, lfsr_q, lfsr_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]        fill_q, fill_d;
  logic [CNT_W-1:0]   tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d, err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0]   mis_cnt_q, mis_cnt_d, lost_cnt_q, lost_cnt_d;
  logic [N_PKT-1:0]   mem_q [EXP_DEPTH];

  logic               w_fire, w_push, w_pop_rx, w_pop_to, w_pop, w_drop;
  logic               w_empty, w_full;
  logic [N_PKT-1:0]   w_pattern, w_lfsr_next, w_head;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

  // Pattern source selected at fire time.
  always_comb begin
    case (pat_sel)
      2'd1:    w_pattern = inc_q;
      2'd2:    w_pattern = lfsr_q;
      default: w_pattern = static_data;
    endcase
  end

  // Fibonacci step; the all-zero lock-up state is forced back to 1.
  always_comb begin
    w_lfsr_next = {lfsr_q[N_PKT-2:0], ^(lfsr_q & LFSR_TAPS)};
    if (w_lfsr_next == '0) w_lfsr_next = N_PKT'(1);
  end

  // Sequencer: decides when to fire and tracks the Encoder handshake.
  always_comb begin
    state_d     = state_q;
    tx_start_d  = 1'b0;
    tx_data_d   = tx_data_q;
    burst_rem_d = burst_rem_q;
    gap_cnt_d   = gap_cnt_q;
    w_fire      = 1'b0;
    case (state_q)
      S_IDLE:    if ((mode != 2'd0) && tx_avail) state_d = S_READY;
      S_READY: begin
        case (mode)
          2'd0:    state_d = S_IDLE;
          2'd1:    w_fire  = trigger;
          2'd2:    w_fire  = 1'b1;
          default: if (trigger) begin
            w_fire      = 1'b1;
            burst_rem_d = (burst_len == '0) ? BURST_W'(1) : burst_len;
          end
        endcase
      end
      S_WAIT_LO: if (!tx_avail) state_d = S_WAIT_HI;
      S_WAIT_HI: if (tx_avail) begin
        state_d   = S_GAP;
        gap_cnt_d = '0;
      end
      S_GAP: begin
        gap_cnt_d = gap_cnt_q + GAP_W'(1);
        // Mode is re-read here so a mode change takes effect between packets.
        if (gap_cnt_q >= gap) begin
          if ((mode == 2'd2) || ((mode == 2'd3) && (burst_rem_q != '0))) w_fire = 1'b1;
          else state_d = S_READY;
        end
      end
      default:   state_d = S_IDLE;
    endcase
    if (w_fire) begin
      state_d    = S_WAIT_LO;
      tx_start_d = 1'b1;
      tx_data_d  = w_pattern;
      if (mode == 2'd3) burst_rem_d = burst_rem_d - BURST_W'(1);
    end
  end

  // Expected-packet FIFO and checker.
  assign w_empty  = (fill_q == '0);
  assign w_full   = (fill_q == C_DEPTH);
  assign w_head   = mem_q[rd_ptr_q];
  assign w_push   = w_fire && !clr;   // clr empties the FIFO, so it wins over a push
  assign w_pop_rx = rx_avail && !w_empty;
  assign w_pop    = w_pop_rx || w_pop_to;
  // A full FIFO with a simultaneous pop has room, so nothing is lost.
  assign w_drop   = w_push && w_full && !w_pop;

`ifdef LINK_EXERCISER_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  assign w_pop_to = !w_empty && !rx_avail && (to_cnt_q == TO_W'(TIMEOUT - 1));

  always_comb begin
    if (clr || w_empty || rx_avail || w_pop_to) to_cnt_d = '0;
    else                                         to_cnt_d = to_cnt_q + TO_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) to_cnt_q <= '0;
    else        to_cnt_q <= to_cnt_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign w_pop_to       = 1'b0;
`endif

  always_comb begin
    inc_d      = inc_q;
    lfsr_d     = lfsr_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fill_d     = fill_q;
    tx_cnt_d   = tx_cnt_q;
    rx_cnt_d   = rx_cnt_q;
    err_cnt_d  = err_cnt_q;
    mis_cnt_d  = mis_cnt_q;
    lost_cnt_d = lost_cnt_q;
    if (clr) begin
      inc_d      = '0;
      lfsr_d     = N_PKT'(1);
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      fill_d     = '0;
      tx_cnt_d   = '0;
      rx_cnt_d   = '0;
      err_cnt_d  = '0;
      mis_cnt_d  = '0;
      lost_cnt_d = '0;
    end else begin
      if (w_fire && (pat_sel == 2'd1)) inc_d  = inc_q + N_PKT'(1);
      if (w_fire && (pat_sel == 2'd2)) lfsr_d = w_lfsr_next;
      if (w_push)           wr_ptr_d = wr_ptr_q + AW'(1);
      if (w_pop || w_drop)  rd_ptr_d = rd_ptr_q + AW'(1);
      fill_d     = fill_q + (AW+1)'(w_push) - (AW+1)'(w_pop || w_drop);
      tx_cnt_d   = sat_inc(tx_cnt_q, w_fire);
      rx_cnt_d   = sat_inc(rx_cnt_q, rx_avail);
      err_cnt_d  = sat_inc(err_cnt_q, rx_error);
      mis_cnt_d  = sat_inc(mis_cnt_q, rx_avail && (w_empty || (rx_data != w_head)));
      lost_cnt_d = sat_inc(lost_cnt_q, w_drop || w_pop_to);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q] <= w_pattern;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      tx_start_q  <= 1'b0;
      tx_data_q   <= '0;
      burst_rem_q <= '0;
      gap_cnt_q   <= '0;
      inc_q       <= '0;
      lfsr_q      <= N_PKT'(1);
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fill_q      <= '0;
      tx_cnt_q    <= '0;
      rx_cnt_q    <= '0;
      err_cnt_q   <= '0;
      mis_cnt_q   <= '0;
      lost_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      tx_start_q  <= tx_start_d;
      tx_data_q   <= tx_data_d;
      burst_rem_q <= burst_rem_d;
      gap_cnt_q   <= gap_cnt_d;
      inc_q       <= inc_d;
      lfsr_q      <= lfsr_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fill_q      <= fill_d;
      tx_cnt_q    <= tx_cnt_d;
      rx_cnt_q    <= rx_cnt_d;
      err_cnt_q   <= err_cnt_d;
      mis_cnt_q   <= mis_cnt_d;
      lost_cnt_q  <= lost_cnt_d;
    end
  end

  assign tx_start       = tx_start_q;
  assign tx_data        = tx_data_q;
  assign rx_read        = 1'b1;
  assign tx_count       = tx_cnt_q;
  assign rx_count       = rx_cnt_q;
  assign err_count      = err_cnt_q;
  assign mismatch_count = mis_cnt_q;
  assign lost_count     = lost_cnt_q;
  assign busy           = (state_q != S_IDLE) && (state_q != S_READY);

endmodule
`default_nettype wire

// File: tb/tb_link_exerciser.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_link_exerciser                                               |
// | Directed bench for link_exerciser with a loopback Encoder/Decoder model. |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_link_exerciser;
  localparam int PKT_LEN = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic        trigger = 1'b0;
  logic [31:0] gap = 32'd0;
  logic [7:0]  burst_len = 8'd0;
  logic [1:0]  pat_sel = 2'd0;
  logic [7:0]  static_data = 8'd0;
  logic        clr = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic [7:0]  rx_data;
  logic        rx_avail, rx_error, rx_read, busy;
  logic [31:0] tx_count, rx_count, err_count, mismatch_count, lost_count;

  // Loopback model state
  logic        m_avail = 1'b1;
  int          m_busy = 0;
  int          m_pkt = 0;
  logic [7:0]  m_data = 8'd0;
  logic        m_rx_avail = 1'b0;
  logic        m_rx_err = 1'b0;
  logic [7:0]  m_rx_data = 8'd0;
  bit          rx_en = 1'b1;
  int          flip_at = -1;
  int          err_at = -1;
  logic        inj_avail = 1'b0;
  logic [7:0]  inj_data = 8'd0;

  // Monitor
  int          n_start = 0;
  longint      cyc = 0;
  logic [7:0]  txq [128];
  longint      stime [128];

  int n_vec = 0;
  int n_err = 0;
  int base, base2;

  assign rx_avail = m_rx_avail | inj_avail;
  assign rx_data  = inj_avail ? inj_data : m_rx_data;
  assign rx_error = m_rx_err;

  link_exerciser #(.TIMEOUT(100)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .trigger(trigger), .gap(gap),
    .burst_len(burst_len), .pat_sel(pat_sel), .static_data(static_data), .clr(clr),
    .tx_data(tx_data), .tx_start(tx_start), .tx_avail(m_avail),
    .rx_data(rx_data), .rx_avail(rx_avail), .rx_error(rx_error), .rx_read(rx_read),
    .tx_count(tx_count), .rx_count(rx_count), .err_count(err_count),
    .mismatch_count(mismatch_count), .lost_count(lost_count), .busy(busy)
  );

  always #5 clk = ~clk;

  // Encoder busy for PKT_LEN cycles after a start; Decoder delivers the packet
  // in the cycle the Encoder becomes idle again.
  always @(posedge clk) begin
    m_rx_avail <= 1'b0;
    m_rx_err   <= 1'b0;
    if (tx_start) begin
      m_busy  <= PKT_LEN;
      m_avail <= 1'b0;
      m_data  <= tx_data;
    end else if (m_busy > 0) begin
      m_busy <= m_busy - 1;
      if (m_busy == 1) begin
        m_avail <= 1'b1;
        m_pkt   <= m_pkt + 1;
        if (rx_en) begin
          m_rx_avail <= 1'b1;
          m_rx_data  <= (m_pkt == flip_at) ? (m_data ^ 8'h01) : m_data;
          m_rx_err   <= (m_pkt == err_at);
        end
      end
    end
  end

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (tx_start && n_start < 128) begin
      txq[n_start]   = tx_data;
      stime[n_start] = cyc;
      n_start        = n_start + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_trigger();
    @(negedge clk) trigger = 1'b1;
    @(negedge clk) trigger = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk) clr = 1'b1;
    @(negedge clk) clr = 1'b0;
  endtask

  task automatic inject(input logic [7:0] v);
    @(negedge clk) begin inj_avail = 1'b1; inj_data = v; end
    @(negedge clk) inj_avail = 1'b0;
  endtask

  task automatic wait_starts(input string tag, input int target, input int max_cyc);
    int i = 0;
    while (n_start < target && i < max_cyc) begin
      @(negedge clk);
      i++;
    end
    check(tag, 64'(n_start), 64'(target));
  endtask

  task automatic check_counters(input string tag, input int t, input int r,
                                input int e, input int m, input int l);
    check({tag, "_tx"},   tx_count,       64'(t));
    check({tag, "_rx"},   rx_count,       64'(r));
    check({tag, "_err"},  err_count,      64'(e));
    check({tag, "_mis"},  mismatch_count, 64'(m));
    check({tag, "_lost"}, lost_count,     64'(l));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Reset values
    wait_cycles(3);
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_busy", busy, 0);
    check("rst_rx_read", rx_read, 1);
    check_counters("rst", 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    // Single-shot, static A5
    static_data = 8'hA5; pat_sel = 2'd0; mode = 2'd1;
    wait_cycles(3);
    check("ss_ready", busy, 0);
    base = n_start;
    pulse_trigger();
    wait_cycles(40);
    check("ss_starts", 64'(n_start - base), 1);
    check("ss_data", txq[base], 8'hA5);
    check_counters("ss", 1, 1, 0, 0, 0);

    // Continuous incrementing, gap 10: spacing 5 + 10 + 3 = 18
    pulse_clr();
    base = n_start; pat_sel = 2'd1; gap = 32'd10; mode = 2'd2;
    wait_starts("cont_run", base + 20, 600);
    mode = 2'd0;
    wait_cycles(40);
    check("cont_starts", 64'(n_start - base), 20);
    for (int i = 0; i < 20; i++) check("cont_data", txq[base + i], 64'(i));
    check("cont_space_first", 64'(stime[base + 1] - stime[base]), 18);
    check("cont_space_last", 64'(stime[base + 19] - stime[base + 18]), 18);
    check_counters("cont", 20, 20, 0, 0, 0);
    check("cont_idle", busy, 0);

    // Burst of 5 with an ignored mid-burst trigger, then burst_len 0
    gap = 32'd2; static_data = 8'h3C; pat_sel = 2'd0;
    pulse_clr();
    mode = 2'd3; burst_len = 8'd5;
    wait_cycles(2);
    check("burst_ready", busy, 0);
    base = n_start;
    pulse_trigger();
    wait_cycles(25);
    check("burst_mid_busy", busy, 1);
    pulse_trigger();
    wait_cycles(60);
    check("burst_starts", 64'(n_start - base), 5);
    check("burst_data", txq[base + 4], 8'h3C);
    check_counters("burst", 5, 5, 0, 0, 0);
    check("burst_end_ready", busy, 0);
    base2 = n_start; burst_len = 8'd0;
    pulse_trigger();
    wait_cycles(30);
    check("burst0_starts", 64'(n_start - base2), 1);
    check("burst0_ready", busy, 0);

    // LFSR run with one corrupted packet and one Decoder error
    pulse_clr();
    mode = 2'd0;
    wait_cycles(2);
    flip_at = m_pkt + 3; err_at = m_pkt + 7;
    pat_sel = 2'd2; base = n_start; mode = 2'd2;
    wait_starts("lfsr_run", base + 10, 400);
    mode = 2'd0;
    wait_cycles(30);
    check("lfsr_0", txq[base + 0], 8'h01);
    check("lfsr_1", txq[base + 1], 8'h02);
    check("lfsr_2", txq[base + 2], 8'h04);
    check("lfsr_3", txq[base + 3], 8'h08);
    check("lfsr_4", txq[base + 4], 8'h11);
    check_counters("corrupt", 10, 10, 1, 1, 0);
    flip_at = -1; err_at = -1;

    // Overflow with receiver disconnected, then injected receptions
    rx_en = 1'b0;
    pulse_clr();
    pat_sel = 2'd1; base = n_start; mode = 2'd2;
    wait_starts("ovf_run", base + 6, 200);
    mode = 2'd0;
    wait_cycles(12);
    check_counters("ovf", 6, 0, 0, 0, 2);
    for (int v = 2; v <= 6; v++) inject(8'(v));
    check("inj_rx", rx_count, 5);
    check("inj_mis", mismatch_count, 1);
    rx_en = 1'b1;
    pulse_clr();
    check_counters("clr", 0, 0, 0, 0, 0);

`ifdef LINK_EXERCISER_TIMEOUT_EN
    // Lost-packet timeout (TIMEOUT = 100)
    rx_en = 1'b0; pat_sel = 2'd0; mode = 2'd1;
    wait_cycles(3);
    base = n_start;
    pulse_trigger();
    wait_starts("to_run", base + 1, 20);
    wait_cycles(98);
    check("to_before", lost_count, 0);
    wait_cycles(1);
    check("to_hit", lost_count, 1);
    wait_cycles(150);
    check("to_hold", lost_count, 1);
    rx_en = 1'b1;
`endif

    // Reset mid-packet
    mode = 2'd1;
    wait_cycles(3);
    pulse_trigger();
    check("rstmid_start", tx_start, 1);
    check("rstmid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("rstmid_start_drop", tx_start, 0);
    check("rstmid_idle", busy, 0);
    wait_cycles(2);
    rst_n = 1'b1;
    wait_cycles(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
